// File: rtl/fire2_3_expand3_sched.sv
// Sequencer for the shared fire2/fire3 expand-3x3 MAC array: layer enables, padded 3x3 ifm
// read address stream, delayed ofm write strobes and the inter-layer handshake.
module fire2_3_expand3_sched #(
  parameter int WOUT       = 64,
  parameter int W_IN       = 64,
  parameter int CHIN       = 16,
  parameter int KERNEL_DIM = 3,
  parameter int PAD        = 1,
  parameter int OFM_LAT    = 2,
  localparam int ADDR_W    = $clog2(CHIN * W_IN * W_IN),
  localparam int PIX_W     = $clog2(WOUT * WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fire2_finish,
  input  logic              fire3_finish,
  input  logic              ram_feedback_2,
  input  logic              ram_feedback_3,
  output logic              fire2_en,
  output logic              fire3_en,
  output logic              ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_rd_addr,
  output logic              ifm_pad,
  output logic              ofm_wr_en,
  output logic [PIX_W-1:0]  ofm_wr_addr,
  output logic              busy,
  output logic              done
);
  localparam int NPIX   = WOUT * WOUT;
  localparam int PERIOD = KERNEL_DIM * KERNEL_DIM * CHIN + 1;
  localparam int T_W    = $clog2(PERIOD);
  localparam int CH_W   = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int KX_W   = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
  localparam int KY_W   = $clog2(KERNEL_DIM + 1);
  localparam int C_W    = (WOUT > 1) ? $clog2(WOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN2, S_WAIT2, S_RUN3, S_WAIT3, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [KX_W-1:0]   kx_q, kx_d;
  logic [KY_W-1:0]   ky_q, ky_d;
  logic [PIX_W-1:0]  p_q, p_d;
  logic [C_W-1:0]    row_q, row_d, col_q, col_d;
  logic              last_q, last_d;
  logic              fin_seen_q, fin_seen_d, fb_seen_q, fb_seen_d;
  logic              fire2_en_q, fire2_en_d, fire3_en_q, fire3_en_d;
  logic              rd_en_q, rd_en_d, pad_q, pad_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OFM_LAT-1:0] dl_vld_q, dl_vld_d;
  logic [PIX_W-1:0]  dl_addr_q [OFM_LAT];
  logic [PIX_W-1:0]  dl_addr_d [OFM_LAT];

  logic run_q, run_d, in_layer, l3, fin_in, fb_in, bub, oob;
  int   y, x;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    ch_d       = ch_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    p_d        = p_q;
    row_d      = row_q;
    col_d      = col_q;
    last_d     = last_q;
    run_q      = (state_q == S_RUN2) || (state_q == S_RUN3);
    in_layer   = run_q || (state_q == S_WAIT2) || (state_q == S_WAIT3);
    l3         = (state_q == S_RUN3) || (state_q == S_WAIT3);
    fin_in     = l3 ? fire3_finish : fire2_finish;
    fb_in      = l3 ? ram_feedback_3 : ram_feedback_2;
    fin_seen_d = fin_seen_q | (in_layer & fin_in);
    fb_seen_d  = fb_seen_q | (in_layer & fb_in);
    bub        = run_q && !last_q && (t_q == T_W'(PERIOD - 1));

    // The last strobe of a layer is the only one still in flight after its final bubble.
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN2;
      S_RUN2:  if (last_q && dl_vld_q[OFM_LAT-1]) state_d = S_WAIT2;
      S_WAIT2: if (fin_seen_d && fb_seen_d) state_d = S_RUN3;
      S_RUN3:  if (last_q && dl_vld_q[OFM_LAT-1]) state_d = S_WAIT3;
      S_WAIT3: if (fin_seen_d && fb_seen_d) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!in_layer || (state_d != state_q && !run_q)) begin
      fin_seen_d = 1'b0;
      fb_seen_d  = 1'b0;
    end

    run_d = (state_d == S_RUN2) || (state_d == S_RUN3);
    if (run_q && state_d == state_q) begin
      if (bub) begin
        t_d  = '0;
        ch_d = '0;
        kx_d = '0;
        ky_d = '0;
        if (p_q == PIX_W'(NPIX - 1)) begin
          last_d = 1'b1;
        end else begin
          p_d = p_q + PIX_W'(1);
          if (col_q == C_W'(WOUT - 1)) begin
            col_d = '0;
            row_d = row_q + C_W'(1);
          end else begin
            col_d = col_q + C_W'(1);
          end
        end
      end else if (!last_q) begin
        t_d = t_q + T_W'(1);
        if (ch_q == CH_W'(CHIN - 1)) begin
          ch_d = '0;
          if (kx_q == KX_W'(KERNEL_DIM - 1)) begin
            kx_d = '0;
            ky_d = ky_q + KY_W'(1);
          end else begin
            kx_d = kx_q + KX_W'(1);
          end
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
    end else if (!run_d || state_d != state_q) begin
      t_d    = '0;
      ch_d   = '0;
      kx_d   = '0;
      ky_d   = '0;
      p_d    = '0;
      row_d  = '0;
      col_d  = '0;
      last_d = 1'b0;
    end

    // Output registers are loaded from next-state counters so they align with t_q.
    y          = int'(row_d) + int'(ky_d) - PAD;
    x          = int'(col_d) + int'(kx_d) - PAD;
    oob        = (y < 0) || (y >= W_IN) || (x < 0) || (x >= W_IN);
    rd_en_d    = run_d && !last_d && (t_d != T_W'(PERIOD - 1));
    pad_d      = rd_en_d && oob;
    addr_d     = (rd_en_d && !oob) ? ADDR_W'((int'(ch_d) * W_IN + y) * W_IN + x) : '0;
    fire2_en_d = (state_d == S_RUN2) || (state_d == S_WAIT2);
    fire3_en_d = (state_d == S_RUN3) || (state_d == S_WAIT3);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);

    dl_vld_d[0]  = bub;
    dl_addr_d[0] = bub ? p_q : '0;
    for (int i = 1; i < OFM_LAT; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      ch_q       <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      p_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      last_q     <= 1'b0;
      fin_seen_q <= 1'b0;
      fb_seen_q  <= 1'b0;
      fire2_en_q <= 1'b0;
      fire3_en_q <= 1'b0;
      rd_en_q    <= 1'b0;
      pad_q      <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dl_vld_q   <= '0;
      for (int i = 0; i < OFM_LAT; i++) dl_addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      ch_q       <= ch_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      p_q        <= p_d;
      row_q      <= row_d;
      col_q      <= col_d;
      last_q     <= last_d;
      fin_seen_q <= fin_seen_d;
      fb_seen_q  <= fb_seen_d;
      fire2_en_q <= fire2_en_d;
      fire3_en_q <= fire3_en_d;
      rd_en_q    <= rd_en_d;
      pad_q      <= pad_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dl_vld_q   <= dl_vld_d;
      for (int i = 0; i < OFM_LAT; i++) dl_addr_q[i] <= dl_addr_d[i];
    end
  end

  assign fire2_en    = fire2_en_q;
  assign fire3_en    = fire3_en_q;
  assign ifm_rd_en   = rd_en_q;
  assign ifm_pad     = pad_q;
  assign ifm_rd_addr = addr_q;
  assign ofm_wr_en   = dl_vld_q[OFM_LAT-1];
  assign ofm_wr_addr = dl_addr_q[OFM_LAT-1];
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_fire2_3_expand3_sched.sv
// Scoreboard bench: expected tap/strobe streams come from a nested-loop window model; a
// negedge monitor pops and compares them, including cycle offsets from each layer start.
module tb_fire2_3_expand3_sched;
  localparam int WOUT = 4, W_IN = 4, CHIN = 2, K = 3, PAD = 1, OFM_LAT = 2;
  localparam int PERIOD = K * K * CHIN + 1;
  localparam int NPIX = WOUT * WOUT;
  localparam int ADDR_W = $clog2(CHIN * W_IN * W_IN);
  localparam int PIX_W = $clog2(NPIX);

  logic clk, rst, start, fire2_finish, fire3_finish, ram_feedback_2, ram_feedback_3;
  logic fire2_en, fire3_en, ifm_rd_en, ifm_pad, ofm_wr_en, busy, done;
  logic [ADDR_W-1:0] ifm_rd_addr;
  logic [PIX_W-1:0]  ofm_wr_addr;
  logic [ADDR_W+PIX_W+6:0] all_out;

  fire2_3_expand3_sched #(.WOUT(WOUT), .W_IN(W_IN), .CHIN(CHIN), .KERNEL_DIM(K), .PAD(PAD),
                          .OFM_LAT(OFM_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .fire2_finish(fire2_finish),
    .fire3_finish(fire3_finish), .ram_feedback_2(ram_feedback_2),
    .ram_feedback_3(ram_feedback_3), .fire2_en(fire2_en), .fire3_en(fire3_en),
    .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr), .ifm_pad(ifm_pad),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .busy(busy), .done(done));

  assign all_out = {fire2_en, fire3_en, ifm_rd_en, ifm_pad, ifm_rd_addr, ofm_wr_en,
                    ofm_wr_addr, busy, done};

  typedef struct { int layer; int off; int pad; int addr; } exp_t;
  exp_t tap_q[$];
  exp_t ofm_q[$];
  exp_t me;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int base2 = 0, base3 = 0, lay, bs, ofm_seen2 = 0, ofm_seen3 = 0, done_cnt = 0;
  bit mon_en = 0, p2 = 0, p3 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_layer(int L);
    exp_t e;
    for (int p = 0; p < NPIX; p++) begin
      int row, col;
      row = p / WOUT;
      col = p % WOUT;
      for (int t = 0; t < PERIOD - 1; t++) begin
        int pos, ch, ky, kx, y, x, oob;
        pos = t / CHIN;
        ch  = t % CHIN;
        ky  = pos / K;
        kx  = pos % K;
        y   = row + ky - PAD;
        x   = col + kx - PAD;
        oob = (y < 0 || y >= W_IN || x < 0 || x >= W_IN) ? 1 : 0;
        e.layer = L;
        e.off   = p * PERIOD + t;
        e.pad   = oob;
        e.addr  = (oob != 0) ? 0 : (ch * W_IN + y) * W_IN + x;
        tap_q.push_back(e);
      end
      e.layer = L;
      e.off   = p * PERIOD + PERIOD - 1 + OFM_LAT;
      e.pad   = 0;
      e.addr  = p;
      ofm_q.push_back(e);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (fire2_en && !p2) base2 = cyc;
      if (fire3_en && !p3) base3 = cyc;
      p2 = fire2_en;
      p3 = fire3_en;
      lay = fire3_en ? 3 : (fire2_en ? 2 : 0);
      bs = (lay == 3) ? base3 : base2;
      if (busy) check("en_exclusive", int'(fire2_en & fire3_en), 0);
      if (ifm_rd_en) begin
        if (tap_q.size() == 0) check("tap_unexpected", 1, 0);
        else begin
          me = tap_q.pop_front();
          check("tap_layer", lay, me.layer);
          check("tap_time", cyc - bs, me.off);
          check("tap_pad", int'(ifm_pad), me.pad);
          check("tap_addr", int'(ifm_rd_addr), me.addr);
        end
      end
      if (ofm_wr_en) begin
        if (ofm_q.size() == 0) check("ofm_unexpected", 1, 0);
        else begin
          me = ofm_q.pop_front();
          check("ofm_layer", lay, me.layer);
          check("ofm_time", cyc - bs, me.off);
          check("ofm_addr", int'(ofm_wr_addr), me.addr);
        end
        if (lay == 3) ofm_seen3++;
        else ofm_seen2++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic wait_ofm(int layer, int n, int budget);
    int k = 0;
    while (((layer == 2) ? ofm_seen2 : ofm_seen3) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(layer == 2 ? "ofm_count_fire2" : "ofm_count_fire3",
          (layer == 2) ? ofm_seen2 : ofm_seen3, n);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(bit abort);
    int k;
    done_cnt = 0; ofm_seen2 = 0; ofm_seen3 = 0; p2 = 0; p3 = 0;
    push_layer(2);
    push_layer(3);
    pulse_start();
    @(negedge clk);
    check("first_tap_flags", int'({fire2_en, fire3_en, ifm_rd_en, ifm_pad}), 4'b1011);
    repeat ($urandom_range(20, 120)) @(posedge clk);
    pulse_start();
    wait_ofm(2, NPIX, 400);
    @(posedge clk); #1 ram_feedback_2 = 1'b1;
    @(posedge clk); #1 ram_feedback_2 = 1'b0;
    repeat ($urandom_range(3, 10)) @(posedge clk);
    pulse_start();
    @(negedge clk);
    check("wait2_hold", int'({fire2_en, fire3_en, ifm_rd_en, ofm_wr_en, busy}), 5'b10001);
    @(posedge clk); #1 fire2_finish = 1'b1;
    @(posedge clk); #1 fire2_finish = 1'b0;
    @(negedge clk);
    check("layer_switch", int'({fire2_en, fire3_en, ifm_rd_en}), 3'b011);
    if (abort) begin
      repeat (7 * PERIOD + 5) @(posedge clk);
      #1 rst = 1'b1;
      mon_en = 1'b0;
      #1 check("abort_outputs", int'(all_out), 0);
      tap_q.delete();
      ofm_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("abort_hold", int'(all_out), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_idle", int'(all_out), 0);
      mon_en = 1'b1;
      return;
    end
    @(posedge clk); #1 fire3_finish = 1'b1;
    @(posedge clk); #1 fire3_finish = 1'b0;
    wait_ofm(3, NPIX, 400);
    repeat ($urandom_range(2, 6)) @(posedge clk);
    #1 ram_feedback_3 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 50);
    check("done_flags", int'({done, busy, fire3_en, fire2_en}), 4'b1100);
    @(negedge clk);
    check("idle_after_done", int'({busy, done, fire2_en, fire3_en}), 0);
    ram_feedback_3 = 1'b0;
    repeat (5) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("tap_queue_empty", tap_q.size(), 0);
    check("ofm_queue_empty", ofm_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fire2_finish = 1'b0; fire3_finish = 1'b0;
    ram_feedback_2 = 1'b0; ram_feedback_3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'(all_out), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("idle_no_start", int'({busy, fire2_en, fire3_en, done}), 0);
    mon_en = 1'b1;
    run(1'b0);
    run(1'b1);
    run(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
